// File: rtl/result_collector.sv
// Receive side of the result display path: reassembles the tagged result stream
// into a 12-byte bank, checks group order, then replays the bank to the display.
module result_collector #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  input  logic [2:0] i_in_group,
  output logic       o_show_valid,
  output logic [7:0] o_show_data,
  output logic [3:0] o_show_index,
  output logic [1:0] o_show_group,
  output logic       o_done,
  output logic       o_error,
  output logic [3:0] o_count,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_data
);

  localparam int              HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SHOW, S_ERROR} state_t;

  state_t        r_state;
  logic [7:0]    r_bank [12];
  logic [3:0]    r_wr_ptr;
  logic [3:0]    r_show_idx;
  logic [HW-1:0] r_hold;
  logic          r_show_valid;
  logic [7:0]    r_show_data;
  logic          r_done;
  logic          r_error;
  logic [7:0]    r_rd_data;

  logic          w_xfer;
  logic [2:0]    w_exp_tag;
  logic [3:0]    w_next_idx;

  assign w_xfer     = i_in_valid && (r_state == S_COLLECT);
  assign w_next_idx = r_show_idx + 4'd1;

  // Expected tag is 0 once the bank is full, so no data tag can match then.
  always_comb begin
    w_exp_tag = 3'd0;
    if (r_wr_ptr < 4'd4)       w_exp_tag = 3'd1;
    else if (r_wr_ptr < 4'd8)  w_exp_tag = 3'd2;
    else if (r_wr_ptr < 4'd12) w_exp_tag = 3'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_show_idx   <= '0;
      r_hold       <= '0;
      r_show_valid <= 1'b0;
      r_show_data  <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_rd_data    <= '0;
      for (int i = 0; i < 12; i++) r_bank[i] <= '0;
    end else begin
      r_done    <= 1'b0;
      // Reads see the bank before this edge's write.
      r_rd_data <= (i_rd_addr < 4'd12) ? r_bank[i_rd_addr] : 8'h00;
      if (i_start) begin
        r_state      <= S_COLLECT;
        r_wr_ptr     <= '0;
        r_error      <= 1'b0;
        r_show_idx   <= '0;
        r_hold       <= '0;
        r_show_valid <= 1'b0;
        r_show_data  <= '0;
        for (int i = 0; i < 12; i++) r_bank[i] <= '0;
      end else begin
        case (r_state)
          S_COLLECT: begin
            if (w_xfer && i_in_group != 3'd0) begin
              if (i_in_group == w_exp_tag) begin
                r_bank[r_wr_ptr] <= i_in_data;
                r_wr_ptr         <= r_wr_ptr + 4'd1;
              end else if (i_in_group == 3'd4 && r_wr_ptr == 4'd12) begin
                r_state      <= S_SHOW;
                r_show_idx   <= '0;
                r_hold       <= '0;
                r_show_valid <= 1'b1;
                r_show_data  <= r_bank[0];
              end else begin
                r_error <= 1'b1;
                r_state <= S_ERROR;
              end
            end
          end
          S_SHOW: begin
            if (r_hold == HOLD_LAST) begin
              r_hold <= '0;
              if (r_show_idx == 4'd11) begin
                r_done       <= 1'b1;
                r_show_valid <= 1'b0;
                r_show_idx   <= '0;
                r_show_data  <= '0;
                r_state      <= S_IDLE;
              end else begin
                r_show_idx  <= w_next_idx;
                r_show_data <= r_bank[w_next_idx];
              end
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_in_ready   = (r_state == S_COLLECT);
  assign o_show_valid = r_show_valid;
  assign o_show_data  = r_show_data;
  assign o_show_index = r_show_idx;
  assign o_show_group = r_show_idx[3:2];
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_count      = r_wr_ptr;
  assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: display and readback streams are
// checked by a monitor against queues filled by the stimulus process.
module tb_result_collector;
  localparam int H = 4;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [2:0] in_group = '0;
  logic [3:0] rd_addr = '0;
  logic       in_ready, show_valid, done, error;
  logic [7:0] show_data, rd_data;
  logic [3:0] show_index, count;
  logic [1:0] show_group;

  result_collector #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_in_data(in_data), .i_in_group(in_group),
    .o_show_valid(show_valid), .o_show_data(show_data), .o_show_index(show_index),
    .o_show_group(show_group), .o_done(done), .o_error(error), .o_count(count),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, exp_done_cyc = -1;
  logic [11:0] show_q[$];
  logic [7:0]  rd_q[$];
  logic        rd_req = 1'b0, rd_pend = 1'b0;
  logic [11:0] e;
  logic [7:0]  vals[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rd_pend = rd_req;
  end

  always @(negedge clk) begin
    if (show_valid) begin
      if (show_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL show_unexpected: got index %0d data %0h expected no display", show_index, show_data);
      end else begin
        e = show_q.pop_front();
        chk("show_data", show_data, e[7:0]);
        chk("show_index", show_index, e[11:8]);
        chk("show_group", show_group, e[11:8] / 4);
        chk("ready_in_show", in_ready, 0);
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_cycle", cyc, exp_done_cyc);
      chk("done_show_valid", show_valid, 0);
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected: got %0h expected nothing queued", rd_data);
      end else chk("rd_data", rd_data, rd_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] g);
    in_valid = 1'b1; in_data = d; in_group = g;
    tick();
    in_valid = 1'b0; in_group = 3'd0;
  endtask

  task automatic load_nominal();
    for (int i = 0; i < 12; i++) send(vals[i], 3'(1 + i / 4));
  endtask

  task automatic send_term_with_show();
    for (int i = 0; i < 12; i++)
      for (int h = 0; h < H; h++) show_q.push_back({4'(i), vals[i]});
    exp_done_cyc = cyc + 1 + 12 * H;
    send(8'h00, 3'd4);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a; rd_req = 1'b1; rd_q.push_back(exp); tick();
  endtask

  task automatic rd_end();
    rd_req = 1'b0; tick(); tick();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_show_valid"}, show_valid, 0);
    chk({tag, "_show_data"}, show_data, 0);
    chk({tag, "_show_index"}, show_index, 0);
    chk({tag, "_show_group"}, show_group, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    int base;
    for (int i = 0; i < 12; i++) vals[i] = {4'(1 + i / 4), 4'(1 + i % 4)};

    // Reset state
    repeat (2) tick();
    all_zero("reset");
    reset = 1'b0;
    tick();

    // Nominal collect and show
    pulse_start();
    chk("start_ready", in_ready, 1);
    chk("start_count", count, 0);
    load_nominal();
    chk("nom_count", count, 12);
    chk("nom_error", error, 0);
    base = done_cnt;
    send_term_with_show();
    chk("show_entry_ready", in_ready, 0);
    chk("show_entry_valid", show_valid, 1);
    for (int t = 0; t < 80 && done_cnt == base; t++) tick();
    chk("nom_done_pulses", done_cnt, base + 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("show_q_drained", show_q.size(), 0);
    chk("idle_ready", in_ready, 0);

    // Readback after nominal load
    rd(4'd0, 8'h11); rd(4'd5, 8'h22); rd(4'd11, 8'h34); rd(4'd13, 8'h00);
    rd_end();

    // Gaps and idle tags
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      in_group = 3'd5; tick(); in_group = 3'd0;
      send(8'hEE, 3'd0);
      send(vals[i], 3'(1 + i / 4));
    end
    chk("gap_error", error, 0);
    chk("gap_count", count, 12);
    for (int i = 0; i < 12; i++) rd(4'(i), vals[i]);
    rd_end();

    // Order error
    pulse_start();
    send(8'hA1, 3'd1); send(8'hA2, 3'd1); send(8'hB1, 3'd2);
    chk("ord_error", error, 1);
    chk("ord_count", count, 2);
    chk("ord_ready", in_ready, 0);
    rd(4'd2, 8'h00); rd(4'd1, 8'hA2);
    rd_end();
    send(8'hC1, 3'd1);
    chk("err_sticky_count", count, 2);
    chk("err_sticky", error, 1);
    pulse_start();
    chk("clr_error", error, 0);
    chk("clr_count", count, 0);
    chk("clr_ready", in_ready, 1);

    // Early done tag
    for (int i = 0; i < 8; i++) send(vals[i], 3'(1 + i / 4));
    base = done_cnt;
    send(8'h00, 3'd4);
    chk("early_error", error, 1);
    chk("early_count", count, 8);
    chk("early_no_show", show_valid, 0);
    repeat (60) tick();
    chk("early_no_done", done_cnt, base);

    // Reset abort during SHOW
    pulse_start();
    load_nominal();
    send_term_with_show();
    for (int t = 0; t < 100 && show_index != 4'd6; t++) tick();
    chk("abort_at_idx", show_index, 6);
    base = done_cnt;
    reset = 1'b1;
    #1;
    all_zero("abort");
    show_q.delete();
    repeat (3) tick();
    chk("abort_no_done", done_cnt, base);
    reset = 1'b0;
    tick();

    // start coincident with a beat
    pulse_start();
    send(8'h61, 3'd1); send(8'h62, 3'd1);
    chk("pre_count", count, 2);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h63; in_group = 3'd1;
    tick();
    start = 1'b0; in_valid = 1'b0; in_group = 3'd0;
    chk("drop_count", count, 0);
    chk("drop_error", error, 0);
    chk("drop_ready", in_ready, 1);
    rd(4'd0, 8'h00);
    rd_end();
    send(8'h64, 3'd1);
    chk("after_drop_count", count, 1);
    rd(4'd0, 8'h64);
    rd_end();

    chk("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
